stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  N-channel, W-bit streaming multiplexer with valid/ready handshake and internal arbitration.
//  Parametrised successor of the fixed 4-to-1, 2-bit select mux.
//  Selection is decided inside the block: fixed priority or round-robin.
//  The result lands in a registered output stage.
//  Sits between several producer streams and a single consumer (bus or FIFO write port).
// PARAMETERS
//  N_CH    4   number of input channels, >= 2
//  W       2   data width per channel, >= 1
//  RR_MODE 1   1 = round-robin arbitration; 0 = fixed priority, lowest index wins
//  CW      $clog2(N_CH)  channel-index width (derived, not overridden)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   N_CH    per-channel data valid
//  in_data    in   N_CH*W  channel i occupies bits [i*W +: W]
//  in_ready   out  N_CH    per-channel accept; at most one bit high per cycle
//  out_valid  out  1       output register holds a word
//  out_data   out  W       selected word
//  out_chan   out  CW      source channel of out_data
//  out_ready  in   1       consumer accepts the word
// BEHAVIOUR
//  Reset (async assert, sync release) clears all state:
//   - out_valid=0, out_data=0, out_chan=0
//   - rr_ptr=0; in_ready=0 while rst_n=0
//  load = !out_valid || out_ready; the output register may take a new word this cycle.
//  Arbitration is combinational over in_valid:
//   - RR_MODE=1: first requester at or after rr_ptr, searching upward with wrap N_CH-1 -> 0.
//   - RR_MODE=0: lowest-index requester.
//  in_ready[g] = load && in_valid[g] for the granted channel g; all other bits are 0.
//  Transfer on channel g when in_valid[g] && in_ready[g]; on the next edge:
//   - out_data <= in_data[g], out_chan <= g, out_valid <= 1
//   - RR_MODE=1 only: rr_ptr <= (g==N_CH-1) ? 0 : g+1
//  Latency: exactly 1 cycle from input transfer to out_valid.
//  Full throughput: one word per cycle when out_ready is held high.
//  Back-pressure: out_valid && !out_ready
//   - out_data and out_chan hold stable; in_ready is all 0; rr_ptr holds.
//  Drain: out_ready && no requester -> out_valid <= 0; out_data and out_chan keep last value.
//  Simultaneous pop and push in one cycle: the new word replaces the old; out_valid stays 1.
//  rr_ptr moves only on a transfer, never on idle cycles.
//  A requester stays pending while a higher-priority channel is served.
//  RR guarantees every channel is served within N_CH transfers.
//  Producers keep in_valid/in_data stable until accepted.
//   - The block does not check this; withdrawal before grant is allowed and simply drops the request.
//  Reset mid-transfer: the held word is discarded and out_valid drops immediately (async).
//  Non-power-of-two N_CH: rr_ptr never exceeds N_CH-1; indices >= N_CH are never granted.
// STRUCTURE
//  Shared package mux_pkg:
//   - function clog2_min1(n): returns 1 for n<=2
//   - typedef chan_idx_t for channel indices
//  Sub-module rr_arbiter (req[N_CH], ptr, en_rr -> gnt onehot, gnt_idx, any).
//   - Combinational; reused by future bus arbiters.
//  Top holds rr_ptr, the output register and the data select (indexed part-select by gnt_idx).
// TESTING  (N_CH=4, W=2, in_data = {2'b11,2'b10,2'b01,2'b00}, i.e. channel i carries value i)
//  1 Reset: rst_n=0 with all in_valid=1
//     -> out_valid=0, out_data=0, out_chan=0, in_ready=0.
//     Release, then ready=1 -> first grant is ch0.
//  2 Single channel: in_valid=4'b0100 for one cycle, out_ready=1
//     -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=2'b10, out_chan=2.
//  3 RR fairness: in_valid=4'b1111 held, out_ready=1
//     -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles.
//  4 RR skip/wrap: rr_ptr=3 with in_valid=4'b0011
//     -> grant ch0, then ch1; ch3 and ch2 are not granted.
//  5 Back-pressure: out_valid=1, out_chan=1, out_ready=0 for 3 cycles with in_valid=4'b1111
//     -> in_ready=0 and outputs stable.
//     Then out_ready=1 -> ch2 granted in the same cycle and appears next cycle.
//  6 Fixed priority (RR_MODE=0): in_valid=4'b1110 held, out_ready=1
//     -> out_chan stays 1 every cycle; lowering in_valid[1] -> out_chan becomes 2.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer and its arbiter.
//  - clog2_min1 : channel-index width that never collapses to zero bits
//  - chan_idx_t : wide unsigned channel index used for range comparisons
package mux_pkg;

    localparam int CHAN_IDX_MAX_W = 16;

    typedef logic [CHAN_IDX_MAX_W-1:0] chan_idx_t;

    // Index width for n items; a 1- or 2-entry set still needs one bit.
    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: round-robin from a start pointer, or fixed
// priority (lowest index wins) when en_rr is low.
// Ports:
//  req     in  N_CH  request vector
//  ptr     in  CW    highest-priority index for round-robin search
//  en_rr   in  1     1 = round-robin from ptr, 0 = search from index 0
//  gnt     out N_CH  one-hot grant (all zero when no request)
//  gnt_idx out CW    binary index of the granted request
//  any     out 1     at least one request present
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CW   = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   ptr,
    input  logic            en_rr,
    output logic [N_CH-1:0] gnt,
    output logic [CW-1:0]   gnt_idx,
    output logic            any
);

    chan_idx_t       start_s;
    logic [N_CH-1:0] upper_mask_s;
    logic [N_CH-1:0] cand_s;

    // An out-of-range pointer falls back to index 0 so phantom indices never win.
    assign start_s = (en_rr && (chan_idx_t'(ptr) < chan_idx_t'(N_CH))) ? chan_idx_t'(ptr)
                                                                       : {CHAN_IDX_MAX_W{1'b0}};

    // Requests at or above the start index have priority over the wrapped-around ones.
    always_comb begin
        upper_mask_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            upper_mask_s[i] = (chan_idx_t'(i) >= start_s);
        end
    end

    assign cand_s = (|(req & upper_mask_s)) ? (req & upper_mask_s) : req;
    assign any    = |req;
    // Isolate the lowest set bit of the candidate set.
    assign gnt    = cand_s & ~(cand_s - {{(N_CH-1){1'b0}}, 1'b1});

    // Binary encode: scanning downward lets the lowest candidate overwrite the rest.
    always_comb begin
        gnt_idx = {CW{1'b0}};
        for (int i = N_CH - 1; i >= 0; i--) begin
            gnt_idx = cand_s[i] ? CW'(i) : gnt_idx;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with internal arbitration and a
// registered output stage (one-cycle latency, full throughput).
// Ports:
//  clk       in  1       rising-edge clock
//  rst_n     in  1       asynchronous active-low reset
//  in_valid  in  N_CH    per-channel valid
//  in_data   in  N_CH*W  channel i at bits [i*W +: W]
//  in_ready  out N_CH    per-channel accept, at most one bit set
//  out_valid out 1       output register holds a word
//  out_data  out W       selected word
//  out_chan  out CW      source channel of out_data
//  out_ready in  1       consumer accepts the word
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int W       = 2,
    parameter int RR_MODE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_CH-1:0]               in_valid,
    input  logic [N_CH*W-1:0]             in_data,
    output logic [N_CH-1:0]               in_ready,
    output logic                          out_valid,
    output logic [W-1:0]                  out_data,
    output logic [clog2_min1(N_CH)-1:0]   out_chan,
    input  logic                          out_ready
);

    localparam int CW = clog2_min1(N_CH);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [CW-1:0]   out_chan_q,  out_chan_d;
    logic [CW-1:0]   rr_ptr_q,    rr_ptr_d;

    logic [N_CH-1:0] gnt_s;
    logic [CW-1:0]   gnt_idx_s;
    logic            any_s;
    logic            load_s;
    logic            xfer_s;
    logic [W-1:0]    sel_data_s;
    logic [CW-1:0]   nxt_ptr_s;

    rr_arbiter #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .en_rr   (RR_MODE != 0),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    // The output register can take a word when empty or being popped this cycle.
    // rst_n gates the handshake so nothing is accepted while reset is held.
    assign load_s   = !out_valid_q || out_ready;
    assign xfer_s   = rst_n && load_s && any_s;
    assign in_ready = (rst_n && load_s) ? gnt_s : {N_CH{1'b0}};

    assign nxt_ptr_s = (gnt_idx_s == CW'(N_CH - 1)) ? {CW{1'b0}} : (gnt_idx_s + {{(CW-1){1'b0}}, 1'b1});

    // Data select: pick the W-bit slice of the granted channel.
    always_comb begin
        sel_data_s = {W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            sel_data_s = (gnt_idx_s == CW'(i)) ? in_data[i*W +: W] : sel_data_s;
        end
    end

    // Next state of the output stage and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_chan_d  = gnt_idx_s;
            rr_ptr_d    = (RR_MODE != 0) ? nxt_ptr_s : rr_ptr_q;
        end else if (out_ready) begin
            // Drain: word consumed and nothing new; data/chan keep last value.
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output stage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {W{1'b0}};
            out_chan_q  <= {CW{1'b0}};
            rr_ptr_q    <= {CW{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

    localparam int N = 4;
    localparam int W = 2;
    localparam logic [7:0] FIXED_DATA = 8'b11_10_01_00;

    logic         clk;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [7:0]   in_data;
    logic         out_ready;

    logic [3:0]   rdy_rr, rdy_fp;
    logic         ov_rr, ov_fp;
    logic [1:0]   od_rr, od_fp;
    logic [1:0]   oc_rr, oc_fp;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: index 0 = round-robin DUT, 1 = fixed-priority DUT.
    int m_valid[2];
    int m_data[2];
    int m_chan[2];
    int m_ptr[2];

    stream_mux_rr #(.N_CH(N), .W(W), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_chan(oc_rr),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.N_CH(N), .W(W), .RR_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_fp), .out_valid(ov_fp), .out_data(od_fp), .out_chan(oc_fp),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First requester found walking upward from p with wrap-around; -1 if none.
    function automatic int model_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic reset_models();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0; m_data[d] = 0; m_chan[d] = 0; m_ptr[d] = 0;
        end
    endtask

    // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
    task automatic cycle();
        int ld, g;
        int nv[2], nd[2], nc[2], np[2];
        logic [3:0] er;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            ld = (m_valid[d] == 0 || out_ready) ? 1 : 0;
            g  = model_grant(in_valid, m_ptr[d]);
            er = 4'b0000;
            nv[d] = m_valid[d]; nd[d] = m_data[d]; nc[d] = m_chan[d]; np[d] = m_ptr[d];
            if (ld == 1 && g >= 0) begin
                er    = 4'(1 << g);
                nv[d] = 1;
                nd[d] = int'((in_data >> (g * W)) & 8'h03);
                nc[d] = g;
                np[d] = (d == 0) ? (g + 1) % N : 0;
            end else if (out_ready) begin
                nv[d] = 0;
            end
            check(d == 0 ? "rr in_ready" : "fp in_ready", d == 0 ? rdy_rr : rdy_fp, er);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = nv[d]; m_data[d] = nd[d]; m_chan[d] = nc[d]; m_ptr[d] = np[d];
        end
        check("rr out_valid", ov_rr, m_valid[0]);
        check("fp out_valid", ov_fp, m_valid[1]);
        if (m_valid[0] != 0) begin
            check("rr out_data", od_rr, m_data[0]);
            check("rr out_chan", oc_rr, m_chan[0]);
        end
        if (m_valid[1] != 0) begin
            check("fp out_data", od_fp, m_data[1]);
            check("fp out_chan", oc_fp, m_chan[1]);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = FIXED_DATA;
        out_ready = 1'b0;
        reset_models();

        // Reset with every channel requesting.
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", ov_rr, 1'b0);
        check("reset out_data",  od_rr, 2'b00);
        check("reset out_chan",  oc_rr, 2'b00);
        check("reset in_ready",  rdy_rr, 4'b0000);
        check("reset fp in_ready", rdy_fp, 4'b0000);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("first grant rr", rdy_rr, 4'b0001);
        check("first grant fp", rdy_fp, 4'b0001);
        cycle();
        check("first out_chan", oc_rr, 2'd0);
        in_valid = 4'b0000;
        cycle();

        // Single channel request.
        in_valid = 4'b0100;
        #1;
        check("single in_ready", rdy_rr, 4'b0100);
        cycle();
        check("single out_valid", ov_rr, 1'b1);
        check("single out_data",  od_rr, 2'b10);
        check("single out_chan",  oc_rr, 2'd2);
        in_valid = 4'b0000;
        cycle();

        // Pointer now at 3: requests 0 and 1 must be served by wrapping.
        in_valid = 4'b0011;
        cycle();
        check("wrap first",  oc_rr, 2'd0);
        cycle();
        check("wrap second", oc_rr, 2'd1);
        in_valid = 4'b0000;
        cycle();

        // Serve channel 3 so the pointer returns to 0, then all request.
        in_valid = 4'b1000;
        cycle();
        in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr fairness", oc_rr, k % 4);
        end

        // Back-pressure with channel 1 held in the output register.
        out_ready = 1'b0;
        #1;
        check("bp in_ready", rdy_rr, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp out_valid", ov_rr, 1'b1);
            check("bp out_chan",  oc_rr, 2'd1);
            check("bp out_data",  od_rr, 2'b01);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", rdy_rr, 4'b0100);
        cycle();
        check("bp release out_chan", oc_rr, 2'd2);

        // Fixed priority: lowest requester always wins.
        in_valid = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("fp hold chan1", oc_fp, 2'd1);
        end
        in_valid = 4'b1100;
        cycle();
        check("fp chan2", oc_fp, 2'd2);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            in_valid  = 4'($urandom);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Asynchronous reset while a word is held under back-pressure.
        in_data   = FIXED_DATA;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst rr out_valid", ov_rr, 1'b0);
        check("async rst fp out_valid", ov_fp, 1'b0);
        check("async rst in_ready", rdy_rr, 4'b0000);
        reset_models();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
